// File: rtl/ring_reduce_countdown_pkg.sv
// Shared types and helpers for the ring reduce / countdown block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: state encodings, reduce-operator encodings, and the
// single-bit reduce step that the top folds across all ring entries.
package rrc_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'b00,
      REDUCE = 2'b01,
      COUNT  = 2'b10
   } state_e;

   // 2'b11 is treated as AND, same as MODE_AND.
   localparam logic [1:0] MODE_AND = 2'b00;
   localparam logic [1:0] MODE_OR  = 2'b01;
   localparam logic [1:0] MODE_XOR = 2'b10;

   // One step of the bitwise fold. Works per bit so it is independent
   // of the entry width chosen by the instantiating module.
   function automatic logic reduce_bit(input logic a, input logic b,
                                       input logic [1:0] mode);
      case (mode)
         MODE_OR:  return a | b;
         MODE_XOR: return a ^ b;
         default:  return a & b;
      endcase
   endfunction

endpackage

// File: rtl/ring_reduce_countdown_key_cond.sv
// Key conditioner: registered rising-edge pulse, optionally debounced.
// Latency: pulse one cycle after the edge sample (DEB_CYCLES=0), or one
// cycle after the DEB_CYCLES-th consecutive high sample. Backpressure: none.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   key        : raw key input, active high
//   pulse      : one-cycle pulse per accepted press
module key_cond #(
   parameter int DEB_CYCLES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic pulse
);

   generate
      if (DEB_CYCLES == 0) begin : g_edge
         logic key_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               key_q <= 1'b0;
               pulse <= 1'b0;
            end else begin
               key_q <= key;
               pulse <= key & ~key_q;
            end
         end
      end else begin : g_deb
         localparam int CW = $clog2(DEB_CYCLES + 1);

         logic          stable;
         logic [CW-1:0] cnt;

         // cnt counts consecutive samples disagreeing with the accepted
         // level; the level flips only after DEB_CYCLES of them, which
         // also re-arms the press only after a debounced release.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stable <= 1'b0;
               cnt    <= '0;
               pulse  <= 1'b0;
            end else if (key != stable) begin
               if (cnt == CW'(DEB_CYCLES - 1)) begin
                  stable <= key;
                  cnt    <= '0;
                  pulse  <= key;
               end else begin
                  cnt    <= cnt + CW'(1);
                  pulse  <= 1'b0;
               end
            end else begin
               cnt   <= '0;
               pulse <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/ring_reduce_countdown.sv
// Ring buffer filled by keys, reduced with AND/OR/XOR, then counted down.
// Latency: reduce result visible one cycle after entering REDUCE / mode change;
// countdown steps every TICKS cycles. Backpressure: none, presses while busy are ignored or abort.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : value written on a load press
//   inc, ld    : raw increment/command key and raw (bouncy) load key
//   mode       : reduce operator 00 AND, 01 OR, 10 XOR, 11 AND
//   data_out   : ring entry at wr_ptr in FILL, otherwise the accumulator
//   state_out  : 00 FILL, 01 REDUCE, 10 COUNT
//   busy       : high in COUNT
// Optional: define RRC_PAUSE_EN to let a load press pause/resume the countdown.
module ring_reduce_countdown
   import rrc_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int DEPTH      = 3,
   parameter int TICKS      = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             inc,
   input  logic             ld,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       state_out,
   output logic             busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;

   state_e           state;
   logic [WIDTH-1:0] ent [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    ptr_next;
   logic [WIDTH-1:0] acc;
   logic [TW-1:0]    timer;
   logic [WIDTH-1:0] red;
   logic             all_nz;
   logic             inc_p;
   logic             ld_p;
   logic             step_en;

   key_cond #(.DEB_CYCLES(0)) u_inc_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (inc),
      .pulse (inc_p)
   );

   key_cond #(.DEB_CYCLES(DEB_CYCLES)) u_ld_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (ld),
      .pulse (ld_p)
   );

   assign ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

   // Bitwise fold of all entries with the selected operator.
   always_comb begin
      red = '0;
      for (int j = 0; j < WIDTH; j++) begin
         red[j] = ent[0][j];
         for (int i = 1; i < DEPTH; i++) begin
            red[j] = reduce_bit(red[j], ent[i][j], mode);
         end
      end
   end

   always_comb begin
      all_nz = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent[i] == '0) all_nz = 1'b0;
      end
   end

`ifdef RRC_PAUSE_EN
   logic paused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         paused <= 1'b0;
      end else if (state != COUNT || inc_p) begin
         paused <= 1'b0;
      end else if (ld_p) begin
         paused <= ~paused;
      end
   end

   assign step_en = ~paused;
`else
   assign step_en = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FILL;
         wr_ptr <= '0;
         acc    <= '0;
         timer  <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         case (state)
            FILL: begin
               // Load wins over a coincident increment; pointer moves once.
               if (ld_p) begin
                  ent[wr_ptr] <= data_in;
                  wr_ptr      <= ptr_next;
               end else if (inc_p) begin
                  wr_ptr <= ptr_next;
               end
               // Uses registered contents, so the completing write
               // transitions one cycle later.
               if (all_nz) state <= REDUCE;
            end

            REDUCE: begin
               acc <= red;
               if (inc_p) begin
                  if (acc == '0) begin
                     for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
                     wr_ptr <= '0;
                     state  <= FILL;
                  end else begin
                     timer <= '0;
                     state <= COUNT;
                  end
               end
            end

            COUNT: begin
               if (inc_p) begin
                  for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
                  wr_ptr <= '0;
                  state  <= FILL;
               end else if (step_en) begin
                  if (timer == TW'(TICKS - 1)) begin
                     timer <= '0;
                     acc   <= acc - WIDTH'(1);
                     // acc >= 1 on entry, so reaching 1 here ends the run.
                     if (acc == WIDTH'(1)) begin
                        for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
                        wr_ptr <= '0;
                        state  <= FILL;
                     end
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
            end

            default: state <= FILL;
         endcase
      end
   end

   assign data_out  = (state == FILL) ? ent[wr_ptr] : acc;
   assign state_out = state;
   assign busy      = (state == COUNT);

endmodule

// File: tb/tb_ring_reduce_countdown.sv
// Self-checking bench for ring_reduce_countdown with a behavioural model.
// Latency: n/a. Backpressure: n/a.
// Model keeps the ring as a plain array plus pointer and derives expected
// reduce values and countdown sequences arithmetically.
module tb_ring_reduce_countdown;

   localparam int WIDTH = 4;
   localparam int DEPTH = 3;
   localparam int TICKS = 8;
   localparam int DEB   = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             inc = 1'b0;
   logic             ld = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [WIDTH-1:0] data_out;
   logic [1:0]       state_out;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: 0 FILL, 1 REDUCE, 2 COUNT.
   int m_ent [DEPTH];
   int m_ptr;
   int m_state;

   ring_reduce_countdown #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .TICKS(TICKS), .DEB_CYCLES(DEB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .inc       (inc),
      .ld        (ld),
      .mode      (mode),
      .data_out  (data_out),
      .state_out (state_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model helpers ----------------
   function automatic int m_fold(input int md);
      int r;
      r = m_ent[0];
      for (int i = 1; i < DEPTH; i++) begin
         if (md == 1)      r = r | m_ent[i];
         else if (md == 2) r = r ^ m_ent[i];
         else              r = r & m_ent[i];
      end
      return r;
   endfunction

   function automatic bit m_all_nz();
      for (int i = 0; i < DEPTH; i++) if (m_ent[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < DEPTH; i++) m_ent[i] = 0;
      m_ptr   = 0;
      m_state = 0;
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      ld = 1'b0; inc = 1'b0;
      #10;
      rst_n = 1'b1;
      m_clear();
   endtask

   // Hold ld for 'hold' sampled cycles, then release long enough to re-arm.
   task automatic ld_press(input int v, input int hold);
      @(posedge clk); #1;
      data_in = WIDTH'(v);
      ld = 1'b1;
      repeat (hold) @(posedge clk);
      #1 ld = 1'b0;
      repeat (DEB + 2) @(posedge clk);
      #1;
      if (hold >= DEB && m_state == 0) begin
         m_ent[m_ptr] = v % (1 << WIDTH);
         m_ptr = (m_ptr + 1) % DEPTH;
      end
      if (m_state == 0 && m_all_nz()) m_state = 1;
   endtask

   // Ends just after the edge at which the press takes effect.
   task automatic inc_press();
      @(posedge clk); #1 inc = 1'b1;
      @(posedge clk); #1 inc = 1'b0;
      @(posedge clk); #1;
      if (m_state == 0) begin
         m_ptr = (m_ptr + 1) % DEPTH;
      end else if (m_state == 1) begin
         if (m_fold(mode) == 0) m_clear();
         else m_state = 2;
      end else begin
         m_clear();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if (data_out !== 4'h0 || state_out !== 2'b00 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: data_out=%h state=%b busy=%b, want 0/00/0",
                  data_out, state_out, busy);
      end
      rst_n = 1'b1;
      m_clear();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (data_out !== 4'h0 || state_out !== 2'b00 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: data_out=%h state=%b busy=%b, want 0/00/0",
                  data_out, state_out, busy);
      end
   endtask

   task automatic test_debounce();
      ld_press(5, DEB - 1);
      @(negedge clk);
      n_cmp++;
      if (data_out !== WIDTH'(m_ent[m_ptr]) || m_ptr != 0) begin
         n_err++;
         $display("FAIL deb_short: data_out=%h want %h (ptr model %0d)",
                  data_out, m_ent[m_ptr], m_ptr);
      end
      ld_press(5, DEB);
      @(negedge clk);
      n_cmp++;
      if (data_out !== WIDTH'(m_ent[m_ptr]) || state_out !== 2'b00) begin
         n_err++;
         $display("FAIL deb_one_write: data_out=%h state=%b want %h/00",
                  data_out, state_out, m_ent[m_ptr]);
      end
      inc_press();
      inc_press();
      @(negedge clk);
      n_cmp++;
      if (data_out !== 4'h5) begin
         n_err++;
         $display("FAIL deb_entry0: data_out=%h want 5", data_out);
      end
   endtask

   task automatic test_ld_inc_same();
      do_reset();
      @(posedge clk); #1;
      data_in = 4'h9;
      ld = 1'b1;
      repeat (DEB - 1) @(posedge clk);
      #1 inc = 1'b1;
      @(posedge clk);
      #1 begin ld = 1'b0; inc = 1'b0; end
      repeat (DEB + 2) @(posedge clk);
      #1;
      m_ent[0] = 9; m_ptr = 1;
      @(negedge clk);
      n_cmp++;
      if (data_out !== 4'h0) begin
         n_err++;
         $display("FAIL same_ptr1: data_out=%h want 0", data_out);
      end
      inc_press();
      inc_press();
      @(negedge clk);
      n_cmp++;
      if (data_out !== 4'h9) begin
         n_err++;
         $display("FAIL same_entry0: data_out=%h want 9", data_out);
      end
   endtask

   task automatic test_reduce_modes();
      int want [3] = '{0, 14, 0};
      do_reset();
      mode = 2'b00;
      ld_press(4'hC, DEB);
      ld_press(4'hA, DEB);
      ld_press(4'h6, DEB);
      for (int md = 0; md < 3; md++) begin
         @(posedge clk); #1 mode = 2'(md);
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (state_out !== 2'b01 || data_out !== WIDTH'(want[md]) ||
             data_out !== WIDTH'(m_fold(md))) begin
            n_err++;
            $display("FAIL reduce_mode%0d: data_out=%h state=%b want %h/01",
                     md, data_out, state_out, want[md]);
         end
      end
      inc_press();
      @(negedge clk);
      n_cmp++;
      if (state_out !== 2'b00 || data_out !== 4'h0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reduce_zero_inc: data_out=%h state=%b busy=%b want 0/00/0",
                  data_out, state_out, busy);
      end
      inc_press();
      @(negedge clk);
      n_cmp++;
      if (data_out !== 4'h0) begin
         n_err++;
         $display("FAIL reduce_cleared: data_out=%h want 0", data_out);
      end
   endtask

   // Expects the block just entered COUNT with value v.
   task automatic run_count(input int v, input string tag);
      for (int k = v; k >= 1; k--) begin
         repeat (TICKS) begin
            @(negedge clk);
            n_cmp++;
            if (data_out !== WIDTH'(k) || busy !== 1'b1 || state_out !== 2'b10) begin
               n_err++;
               $display("FAIL %s_step: data_out=%h busy=%b state=%b want %h/1/10",
                        tag, data_out, busy, state_out, k);
            end
         end
      end
      @(negedge clk);
      m_clear();
      n_cmp++;
      if (data_out !== 4'h0 || busy !== 1'b0 || state_out !== 2'b00) begin
         n_err++;
         $display("FAIL %s_done: data_out=%h busy=%b state=%b want 0/0/00",
                  tag, data_out, busy, state_out);
      end
   endtask

   task automatic test_countdown();
      do_reset();
      mode = 2'b00;
      ld_press(7, DEB); ld_press(5, DEB); ld_press(3, DEB);
      inc_press();
      run_count(1, "cnt_one");
      mode = 2'b01;
      ld_press(3, DEB); ld_press(3, DEB); ld_press(3, DEB);
      inc_press();
      run_count(3, "cnt_three");
      ld_press(3, DEB); ld_press(3, DEB); ld_press(3, DEB);
      inc_press();
      repeat (12) @(posedge clk);
      inc_press();
      @(negedge clk);
      n_cmp++;
      if (state_out !== 2'b00 || busy !== 1'b0 || data_out !== 4'h0) begin
         n_err++;
         $display("FAIL cnt_abort: data_out=%h busy=%b state=%b want 0/0/00",
                  data_out, busy, state_out);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         mode = 2'($urandom_range(0, 3));
         for (int n = 0; n < 20 && !m_all_nz(); n++) begin
            if ($urandom_range(0, 2) == 0) inc_press();
            else ld_press($urandom_range(0, 15), $urandom_range(DEB - 2, DEB + 1));
            @(negedge clk);
            n_cmp++;
            if (m_state == 0 && (state_out !== 2'b00 || data_out !== WIDTH'(m_ent[m_ptr]))) begin
               n_err++;
               $display("FAIL rand_fill: data_out=%h state=%b want %h/00",
                        data_out, state_out, m_ent[m_ptr]);
            end else if (m_state == 1 && (state_out !== 2'b01 ||
                                          data_out !== WIDTH'(m_fold(mode)))) begin
               n_err++;
               $display("FAIL rand_full: data_out=%h state=%b want %h/01",
                        data_out, state_out, m_fold(mode));
            end
         end
         while (!m_all_nz()) ld_press($urandom_range(1, 15), DEB);
         @(posedge clk); #1 mode = 2'($urandom_range(0, 3));
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (state_out !== 2'b01 || data_out !== WIDTH'(m_fold(mode))) begin
            n_err++;
            $display("FAIL rand_reduce: data_out=%h state=%b want %h/01",
                     data_out, state_out, m_fold(mode));
         end
         if (m_fold(mode) == 0) begin
            inc_press();
            @(negedge clk);
            n_cmp++;
            if (state_out !== 2'b00 || data_out !== 4'h0) begin
               n_err++;
               $display("FAIL rand_zero: data_out=%h state=%b want 0/00",
                        data_out, state_out);
            end
         end else if ($urandom_range(0, 1) == 0) begin
            inc_press();
            run_count(m_fold(mode), "rand_cnt");
         end else begin
            int v = m_fold(mode);
            inc_press();
            repeat ($urandom_range(0, TICKS * v - 6)) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1) begin
               n_err++;
               $display("FAIL rand_busy: busy=%b want 1", busy);
            end
            inc_press();
            @(negedge clk);
            n_cmp++;
            if (state_out !== 2'b00 || busy !== 1'b0 || data_out !== 4'h0) begin
               n_err++;
               $display("FAIL rand_abort: data_out=%h busy=%b state=%b want 0/0/00",
                        data_out, busy, state_out);
            end
         end
      end
   endtask

`ifdef RRC_PAUSE_EN
   task automatic test_pause();
      bit done;
      do_reset();
      mode = 2'b01;
      ld_press(2, DEB); ld_press(2, DEB); ld_press(2, DEB);
      inc_press();
      ld_press(0, DEB);
      repeat (20) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (data_out !== 4'h2 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL pause_hold: data_out=%h busy=%b want 2/1", data_out, busy);
      end
      ld_press(0, DEB);
      done = 1'b0;
      for (int c = 0; c < TICKS * 2 + 10 && !done; c++) begin
         @(negedge clk);
         if (state_out == 2'b00) done = 1'b1;
      end
      m_clear();
      n_cmp++;
      if (!done || data_out !== 4'h0) begin
         n_err++;
         $display("FAIL pause_resume: done=%0d data_out=%h want 1/0", done, data_out);
      end
   endtask
`endif

   task automatic test_reset_mid_count();
      do_reset();
      mode = 2'b01;
      ld_press(6, DEB); ld_press(1, DEB); ld_press(2, DEB);
      inc_press();
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (data_out !== 4'h0 || state_out !== 2'b00 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: data_out=%h state=%b busy=%b want 0/00/0",
                  data_out, state_out, busy);
      end
      #3 rst_n = 1'b1;
      m_clear();
      ld_press(9, DEB);
      inc_press();
      inc_press();
      @(negedge clk);
      n_cmp++;
      if (data_out !== 4'h9 || state_out !== 2'b00) begin
         n_err++;
         $display("FAIL reset_next_load: data_out=%h state=%b want 9/00",
                  data_out, state_out);
      end
   endtask

   initial begin
      m_clear();
      test_reset();
      test_debounce();
      test_ld_inc_same();
      test_reduce_modes();
      test_countdown();
      test_random();
`ifdef RRC_PAUSE_EN
      test_pause();
`endif
      test_reset_mid_count();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ring_reduce_countdown.md
Name: ring_reduce_countdown

Overview:
- Parametrised ring buffer of DEPTH entries, each WIDTH bits, filled by button-style load/increment strobes.
- Once every entry is non-zero, the block reduces the buffer with a selectable bitwise operator (AND/OR/XOR).
- On command, it counts the reduced value down to zero at a fixed tick rate, then re-arms.
- Sits between board switches/keys and the display driver in the lab top level.

Parameters:
- WIDTH, 4, bit width of each entry, data_in and data_out.
- DEPTH, 3, number of ring entries (>= 2).
- TICKS, 8, clock cycles per countdown step (>= 1).
- DEB_CYCLES, 4, consecutive stable samples required to accept ld (>= 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  WIDTH  value written on a load
- inc  input  1  raw increment/command key, active high
- ld  input  1  raw load key, active high, bouncy
- mode  input  2  reduce operator: 00 AND, 01 OR, 10 XOR, 11 AND
- data_out  output  WIDTH  displayed value
- state_out  output  2  current state: 00 FILL, 01 REDUCE, 10 COUNT
- busy  output  1  high in COUNT

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is asynchronous and active-low: rst_n.
  - Reset clears all entries, wr_ptr, acc, timer and the conditioners.
  - After reset: state FILL, data_out 0, state_out 00, busy 0.
  - Reset mid-operation aborts immediately, with the same values.
- Input conditioning:
  - inc_p: one-cycle pulse in the cycle after inc is first sampled high (registered rising edge). No further pulse until inc has been sampled low.
  - ld_p: asserted for one cycle once ld has been sampled high for DEB_CYCLES consecutive cycles. Re-armed only after ld is debounced low.
- Pointer: wr_ptr is $clog2(DEPTH) bits and wraps DEPTH-1 -> 0.
- FILL:
  - ld_p writes buf[wr_ptr] <= data_in and advances wr_ptr.
  - inc_p alone advances wr_ptr without writing. If ld_p and inc_p coincide, ld_p wins and wr_ptr advances once.
  - data_out = buf[wr_ptr], combinational from registers.
  - When every buf entry is non-zero, go to REDUCE on the next edge. The check uses registered contents, so a write completing the set transitions one cycle later.
- REDUCE:
  - Every cycle: acc <= reduce(buf, mode). data_out = acc, so there is one cycle of latency after a mode change.
  - inc_p with acc == 0: clear all entries, wr_ptr <= 0, go to FILL.
  - inc_p with acc != 0: timer <= 0, go to COUNT.
  - ld_p is ignored.
- COUNT:
  - timer counts 0..TICKS-1. At TICKS-1: timer <= 0, acc <= acc-1.
  - If acc == 1 at that step: clear entries, wr_ptr <= 0, go to FILL.
  - inc_p in COUNT aborts: clear entries and go to FILL.
  - data_out = acc; busy = 1.
  - acc never underflows, because COUNT is only entered with acc >= 1.
- Arithmetic: WIDTH bits, unsigned. The reduce is a bitwise fold over all DEPTH entries.

Optional Feature:
- Macro: RRC_PAUSE_EN.
- Defined: ld_p in COUNT toggles a pause flag. While paused, timer and acc hold and busy stays 1. The flag is cleared on leaving COUNT and on reset.
- Undefined: ld_p is ignored in COUNT; no pause logic exists.

Decomposition:
- Shared package rrc_pkg holds:
  - state encodings FILL/REDUCE/COUNT;
  - mode encodings MODE_AND/MODE_OR/MODE_XOR;
  - the reduce function.
- Sub-module key_cond (sync edge pulse plus optional debounce, parameter DEB_CYCLES; 0 = edge only) is instantiated twice: inc with 0, ld with DEB_CYCLES.

Test Plan (defaults):
- Reset mid-COUNT -> data_out 0, state_out 00 immediately, busy 0; the next load writes entry 0.
- ld held 3 cycles then released -> no write. ld held 4 cycles with data_in=5 -> buf[0]=5, wr_ptr=1, exactly one write.
- Load 0xC, 0xA, 0x6 -> REDUCE. mode=00 gives 0; mode=01 gives 0xE; mode=10 gives 0x0 (C^A^6 = 0). With acc=0, inc -> FILL with entries cleared.
- Load 0x7, 0x5, 0x3, mode AND (acc=1), inc -> COUNT. After 8 cycles acc reaches 0 and the block returns to FILL with entries cleared.
- Load 3,3,3, mode OR, inc -> data_out sequence 3,2,1, each held 8 cycles, then FILL. A second inc mid-count aborts to FILL.
- ld and inc pulses in the same cycle in FILL -> one write, wr_ptr +1. With RRC_PAUSE_EN, ld in COUNT freezes acc for 20 cycles, then resumes.
